bus_mem_slave: RTL
==================

# bus_mem_slave

Word-addressed memory responder on the system bus. It is the target-side counterpart of the `bus_if` initiator used by the fetch and memory stages: it decodes the slave field of the bus address, accepts one read or write at a time, and inserts a fixed number of wait states. It answers with `bus_rdy_o` and read data. It sits behind the bus arbiter/mux as one of the `2^SLAV_WIDTH` slaves.

## Interface
Parameters:
- `DAT_WIDTH`, 32, data bus width.
- `ADD_WIDTH`, 30, word address width.
- `SLAV_WIDTH`, 3, number of upper address bits selecting the slave.
- `SLAVE_ID`, 0, value of `bus_addr_i[ADD_WIDTH-1 -: SLAV_WIDTH]` that selects this block.
- `MEM_AW`, 10, log2 of memory depth in words; must be ≤ `ADD_WIDTH-SLAV_WIDTH`.
- `WAIT_CYCLES`, 2, wait states inserted between accept and response; 0..15.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: asynchronous active-high reset. This block has one clock; reset is asynchronous and active-high.
- `bus_addr_i`, in, `ADD_WIDTH`: word address.
- `bus_as_i`, in, 1: address strobe, active high.
- `bus_rw_i`, in, 1: 1 = read, 0 = write.
- `bus_wr_data_i`, in, `DAT_WIDTH`: write data.
- `bus_rd_data_o`, out, `DAT_WIDTH`: read data. It is 0 whenever `bus_rdy_o` is 0 or the transfer is a write, so the bus can OR-mux it.
- `bus_rdy_o`, out, 1: one-cycle completion pulse.
- `bus_err_o`, out, 1: error completion. Present only with `BUS_SLV_ERR_EN`.

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - A request is selected when `bus_as_i`=1 and the slave field equals `SLAVE_ID`.
  - On a selected request: latch `addr_q`, `rw_q` and `wdat_q`, and load `cnt` with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES`>0, else RESP.
  - Unselected or absent requests are ignored and all outputs stay 0.
- **WAIT**
  - `cnt` decrements each cycle.
  - Move to RESP on the cycle `cnt`=1.
  - Bus inputs are ignored; deasserting `bus_as_i` does not abort the transfer.
- **RESP**
  - `bus_rdy_o`=1 for exactly this cycle.
  - Read: `bus_rd_data_o = mem[addr_q[MEM_AW-1:0]]`.
  - Write: `mem[addr_q[MEM_AW-1:0]] <= wdat_q` at the clock edge ending RESP.
  - Next state is always IDLE.
- Address offset bits `[ADD_WIDTH-SLAV_WIDTH-1:MEM_AW]` are ignored, so the memory aliases (wraps) across the slave window.
- The memory is not reset. Contents survive `rst_i`.

## Timing
- Reset values: state IDLE, `cnt`=0, `bus_rdy_o`=0, `bus_rd_data_o`=0, `bus_err_o`=0.
- If the request is sampled at edge T, `bus_rdy_o` is high in the cycle after edge T+`WAIT_CYCLES`. Latency is `WAIT_CYCLES`+1 cycles.
- A write is visible to a read accepted after its RESP. A read-after-write to the same address returns the new data.
- After RESP the FSM returns to IDLE and samples `bus_as_i` at the next edge. Back-to-back throughput is one transfer per `WAIT_CYCLES`+2 cycles.
- A master holding `bus_as_i` high after `bus_rdy_o` starts a new transfer. This is the master's responsibility.
- If `rst_i` asserts mid-transfer, the block returns to IDLE immediately, the outputs drop, and a pending write is discarded.
- `bus_rd_data_o` and `bus_rdy_o` are decoded combinationally from the state registers and the async-read array. There is no path from any bus input to any output.

## Configuration
- `BUS_SLV_ERR_EN` defined:
  - A selected request whose ignored offset bits are non-zero is an error.
  - The transfer still goes through WAIT, and RESP asserts `bus_rdy_o`=1 and `bus_err_o`=1.
  - A read returns 0; a write is dropped.
  - `bus_err_o` is 0 in all other cycles.
- `BUS_SLV_ERR_EN` undefined: the `bus_err_o` port is absent and out-of-range offsets alias.

## Structure
- Package `bus_pkg` holds:
  - the `bus_slv_state_e` enum (IDLE/WAIT/RESP);
  - `BUS_READ`=1'b1 and `BUS_WRITE`=1'b0;
  - the default `SLAV_WIDTH`.
- Sub-module `bus_slave_ram`: `2^MEM_AW`×`DAT_WIDTH` array with combinational read and synchronous write enable. No reset.

## Test plan
- Write then read, `SLAVE_ID`=2, `WAIT_CYCLES`=2:
  - write 0xA5A5_1234 to address 0x1000_0004 -> `bus_rdy_o` pulses 3 cycles after accept;
  - then read the same address -> `bus_rd_data_o`=0xA5A5_1234 during the `bus_rdy_o` cycle, 0 otherwise.
- `WAIT_CYCLES`=0: read accepted at edge T -> `bus_rdy_o` high exactly in the cycle after T. Back-to-back reads complete every 2 cycles.
- Request with slave field 3 while `SLAVE_ID`=2 -> no `bus_rdy_o`; memory unchanged.
- Drop `bus_as_i` during WAIT -> the transfer still completes with a single `bus_rdy_o` pulse. Assert `rst_i` during WAIT of a write -> outputs 0 at once; a later read shows the old data.
- Aliasing with `MEM_AW`=10 and the macro off: write 0x55 to offset 0x400 -> read of offset 0x000 returns 0x55.
- Error response with `BUS_SLV_ERR_EN` on: read offset 0x400 -> `bus_rdy_o`=1, `bus_err_o`=1, data 0. Write offset 0x400 -> offset 0x000 unchanged.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for system-bus slaves: slave FSM states, transfer direction
// encoding and the default width of the slave-select address field.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } bus_slv_state_e;

   localparam logic BUS_READ  = 1'b1;
   localparam logic BUS_WRITE = 1'b0;

   localparam int BUS_SLAV_WIDTH = 3;

endpackage

// File: rtl/bus_slave_ram.sv
// Word array behind bus_mem_slave: asynchronous read, synchronous write enable.
// Contents are never reset.
module bus_slave_ram #(
   parameter int DAT_WIDTH = 32,
   parameter int MEM_AW    = 10
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [MEM_AW-1:0]    addr_i,
   input  logic [DAT_WIDTH-1:0] wdata_i,
   output logic [DAT_WIDTH-1:0] rdata_o
);

   logic [DAT_WIDTH-1:0] mem_q [2**MEM_AW];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/bus_mem_slave.sv
// Word-addressed memory slave with a fixed number of wait states per transfer.
// Define BUS_SLV_ERR_EN to add bus_err_o and reject requests with non-zero unused offset bits.
module bus_mem_slave
   import bus_pkg::*;
#(
   parameter int DAT_WIDTH   = 32,
   parameter int ADD_WIDTH   = 30,
   parameter int SLAV_WIDTH  = BUS_SLAV_WIDTH,
   parameter int SLAVE_ID    = 0,
   parameter int MEM_AW      = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [ADD_WIDTH-1:0] bus_addr_i,
   input  logic                 bus_as_i,
   input  logic                 bus_rw_i,
   input  logic [DAT_WIDTH-1:0] bus_wr_data_i,
   output logic [DAT_WIDTH-1:0] bus_rd_data_o,
   output logic                 bus_rdy_o
`ifdef BUS_SLV_ERR_EN
   ,
   output logic                 bus_err_o
`endif
);

   localparam int OFF_W = ADD_WIDTH - SLAV_WIDTH;

   bus_slv_state_e       state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic [MEM_AW-1:0]    addr_q;
   logic                 rw_q;
   logic [DAT_WIDTH-1:0] wdat_q;

   logic                 req_sel;
   logic                 off_nz;
   logic                 req_err;
   logic                 ram_we;
   logic [DAT_WIDTH-1:0] ram_rdata;

   assign req_sel = bus_as_i &&
                    (bus_addr_i[ADD_WIDTH-1 -: SLAV_WIDTH] == SLAV_WIDTH'(SLAVE_ID));

   // Offset bits above the array index; absent when the array fills the slave window.
   generate
      if (OFF_W > MEM_AW) begin : g_off
         assign off_nz = |bus_addr_i[OFF_W-1:MEM_AW];
      end else begin : g_no_off
         assign off_nz = 1'b0;
      end
   endgenerate

`ifdef BUS_SLV_ERR_EN
   assign req_err = off_nz;
`else
   logic unused_off_nz;
   assign unused_off_nz = off_nz;
   assign req_err       = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (req_sel) begin
               cnt_d   = 4'(WAIT_CYCLES);
               err_d   = req_err;
               state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Request payload is only meaningful while a transfer is in flight, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (state_q == IDLE && req_sel) begin
         addr_q <= bus_addr_i[MEM_AW-1:0];
         rw_q   <= bus_rw_i;
         wdat_q <= bus_wr_data_i;
      end
   end

   assign bus_rdy_o     = (state_q == RESP);
   assign ram_we        = bus_rdy_o && (rw_q == BUS_WRITE) && !err_q;
   assign bus_rd_data_o = (bus_rdy_o && (rw_q == BUS_READ) && !err_q) ? ram_rdata : '0;

`ifdef BUS_SLV_ERR_EN
   assign bus_err_o = bus_rdy_o && err_q;
`endif

   bus_slave_ram #(
      .DAT_WIDTH (DAT_WIDTH),
      .MEM_AW    (MEM_AW)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (ram_we),
      .addr_i  (addr_q),
      .wdata_i (wdat_q),
      .rdata_o (ram_rdata)
   );

endmodule
